// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - word-wide instruction memory with byte-lane banks and a byte-stream program loader
// Four 8-bit banks share one word index; the loader assembles little-endian bytes into whole-word writes.
module imem_loadable #(
  parameter int WORD_AW = 9,
  parameter int OUT_REG = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [31:0]        rd_addr,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  input  logic [3:0]         we,
  input  logic [31:0]        wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               ld_start,
  input  logic [31:0]        ld_base,
  input  logic [WORD_AW:0]   ld_count,
  input  logic               ld_abort,
  input  logic               ld_valid,
  input  logic [7:0]         ld_data,
  output logic               ld_ready,
  output logic               ld_busy,
  output logic               ld_done
);

  localparam int DEPTH = 1 << WORD_AW;
  localparam logic [WORD_AW:0] CNT_ONE = {{WORD_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WORD_AW-1:0]   base_q, base_d;
  logic [WORD_AW:0]     count_q, count_d;
  logic [WORD_AW:0]     word_cnt_q, word_cnt_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [23:0]          asm_q, asm_d;

  logic [3:0]           mem_we;
  logic [WORD_AW-1:0]   mem_widx;
  logic [31:0]          mem_wdata;
  logic [WORD_AW-1:0]   rd_idx;
  logic [31:0]          lane_rd;
  logic [31:0]          rd_data_q;
  logic                 rd_valid_q;
  logic                 unused_addr_bits;

  assign rd_idx = rd_addr[WORD_AW+1:2];
  assign unused_addr_bits = ^{rd_addr[31:WORD_AW+2], rd_addr[1:0], wr_addr[31:WORD_AW+2],
                              wr_addr[1:0], ld_base[31:WORD_AW+2], ld_base[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

  // The loader owns the write port while loading; direct writes are dropped then.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    mem_we     = 4'h0;
    mem_widx   = wr_addr[WORD_AW+1:2];
    mem_wdata  = wr_data;
    ld_ready   = 1'b0;
    ld_busy    = 1'b0;
    ld_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_we = we;
        if (ld_start) begin
          if (ld_count != '0) begin
            base_d     = ld_base[WORD_AW+1:2];
            count_d    = ld_count;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            state_d    = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (ld_abort) begin
          state_d = S_IDLE;
        end else if (ld_valid) begin
          if (byte_cnt_q == 2'd3) begin
            mem_we     = 4'hF;
            mem_widx   = base_q + word_cnt_q[WORD_AW-1:0];
            mem_wdata  = {ld_data, asm_q};
            word_cnt_d = word_cnt_q + CNT_ONE;
            byte_cnt_d = 2'd0;
            if (word_cnt_q == count_q - CNT_ONE) state_d = S_DONE;
          end else begin
            case (byte_cnt_q)
              2'd0:    asm_d[7:0]   = ld_data;
              2'd1:    asm_d[15:8]  = ld_data;
              default: asm_d[23:16] = ld_data;
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        ld_done = 1'b1;
        mem_we  = we;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (mem_we[g]) mem[mem_widx] <= mem_wdata[8*g +: 8];
    end
    assign lane_rd[8*g +: 8] = mem[rd_idx];
  end

  // Read-first: the registered read sees the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= lane_rd;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [31:0] rd_data2_q;
    logic        rd_valid2_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data2_q  <= '0;
        rd_valid2_q <= 1'b0;
      end else begin
        rd_valid2_q <= rd_valid_q;
        if (rd_valid_q) rd_data2_q <= rd_data_q;
      end
    end
    assign rd_data  = rd_data2_q;
    assign rd_valid = rd_valid2_q;
  end else begin : g_no_out_reg
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule
